raster_scan_cnt: RTL and testbench
==================================

# raster_scan_cnt

Parametrised raster-scan address counter for the sharpening datapath. It generalises the free-running 5-bit counter into a two-dimensional column/row counter with programmable frame size. It adds start/done handshaking, end-of-line and end-of-frame flags, and a border flag marking pixels whose 3x3-style neighbourhood leaves the frame. It sits between the DLX extension control (START/CLR) and the pixel-fetch address generator, which advances it with CE once per pixel.

## Interface
Parameters:
- COL_W, 8, width of COL output
- ROW_W, 8, width of ROW output
- COLS, 256, pixels per line; 2 <= COLS <= 2^COL_W
- ROWS, 256, lines per frame; 2 <= ROWS <= 2^ROW_W
- BORDER, 1, border thickness in pixels; 0 <= BORDER, 2*BORDER <= min(COLS,ROWS)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- CLR  in  1  synchronous abort/clear, active-high
- START  in  1  begin a frame scan, single-cycle or level
- CE  in  1  advance one pixel, honoured only in RUN
- COL  out  COL_W  current column
- ROW  out  ROW_W  current row
- BUSY  out  1  high in RUN
- EOL  out  1  BUSY & (COL == COLS-1)
- EOF  out  1  EOL & (ROW == ROWS-1)
- EDGE  out  1  BUSY & current pixel lies in the border region
- DONE  out  1  one-cycle pulse after the last pixel is consumed

## Operation
- States: IDLE, RUN, FIN.
- Reset (RST_N=0, asynchronous): state=IDLE, COL=0, ROW=0. Consequently BUSY=EOL=EOF=EDGE=DONE=0.
- Priority on each edge: RST_N, then CLR, then state logic.
- CLR=1 in any state: next state IDLE, COL=0, ROW=0. A pending START in the same cycle is dropped.
- IDLE:
  - START=1 -> RUN, COL=0, ROW=0.
  - CE is ignored.
- RUN, CE=1:
  - If COL != COLS-1: COL+1.
  - Else COL=0, and ROW+1 if ROW != ROWS-1.
  - On the last pixel (EOF=1 with CE=1): COL=0, ROW=0, next state FIN.
- RUN, CE=0: hold all state. START is ignored in RUN.
- FIN:
  - DONE=1 and BUSY=0 for exactly this cycle.
  - START=1 -> RUN (back-to-back frame); otherwise -> IDLE.
- Arithmetic:
  - COL and ROW are unsigned.
  - Comparisons against COLS-1, ROWS-1 and BORDER bounds are performed at full parameter width.
  - No value outside 0..COLS-1 or 0..ROWS-1 ever appears.
  - If COLS = 2^COL_W, the wrap comes from the explicit compare, not from overflow.
- EDGE is true when COL < BORDER, COL >= COLS-BORDER, ROW < BORDER, or ROW >= ROWS-BORDER. With BORDER=0, EDGE is constantly 0.
- Illegal parameter combinations fail elaboration (generate-time check).

## Timing
- START sampled at edge n gives BUSY=1, COL=0, ROW=0 after edge n, so the first CE can be sampled at edge n+1.
- A full frame needs exactly COLS*ROWS cycles with CE=1 in RUN. CE gaps stretch the scan without losing a count.
- DONE rises one cycle after the edge that consumed the last pixel, and lasts one cycle.
- EOL, EOF and EDGE are combinational from registered state. They describe the pixel that the current CE will consume.
- Counter and state outputs are registered. No combinational path runs from inputs to COL, ROW or BUSY.
- A reset asserted mid-frame clears the counters immediately, without waiting for CLK. Deassertion is assumed synchronised upstream.

## Test plan
All cases use COLS=4, ROWS=3, BORDER=1 unless noted.
- Reset: RST_N=0 mid-RUN at COL=2, ROW=1 -> COL=0, ROW=0, BUSY=0 asynchronously. START ignored while RST_N=0.
- Full scan: START, then 12 consecutive CE cycles.
  - COL sequence is 0,1,2,3 repeated and ROW goes 0,0,0,0,1,...,2.
  - EOL is high at COL=3, and EOF is high only at (3,2).
  - DONE pulses once, one cycle after the 12th CE, with BUSY=0 in that cycle.
- CE gaps: as above with CE toggling 1,0.
  - Values hold on CE=0.
  - DONE appears after the 12th CE=1, not after 12 cycles.
- Border: during the full scan, EDGE=0 only at (1,1) and (2,1), and 1 at the other 10 pixels. With BORDER=0, EDGE stays 0.
- Control: START during RUN causes no restart.
  - CLR at (2,1) -> IDLE, COL=0, ROW=0, and no DONE.
  - START held through FIN -> RUN immediately with (0,0).
- Width boundary: COL_W=2, COLS=4, ROW_W=2, ROWS=4 -> COL wraps 3->0 via compare, and DONE follows the 16th CE.

Source files
------------

// File: rtl/raster_scan_cnt.sv
// raster_scan_cnt
// ---------------------------------------------------------------------------
// Two-dimensional raster-scan address counter for the sharpening datapath.
// A frame scan is started with START; every CE in RUN advances one pixel in
// row-major order. After the last pixel a single FIN cycle raises DONE.
//
// Parameters:
//   COL_W, ROW_W  widths of the COL / ROW outputs
//   COLS, ROWS    frame size in pixels / lines
//   BORDER        border thickness used by EDGE (0 disables EDGE)
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   CLR        synchronous abort/clear (wins over START)
//   START      begin a frame scan (sampled in IDLE and FIN)
//   CE         advance one pixel (honoured only in RUN)
//   COL, ROW   current pixel address (registered)
//   BUSY       high in RUN
//   EOL        current pixel is the last of its line
//   EOF        current pixel is the last of the frame
//   EDGE       current pixel lies in the border region
//   DONE       one-cycle pulse after the last pixel is consumed
//   fsm_state  current FSM state (0 IDLE, 1 RUN, 2 FIN) for observation
//
// Handshake: a pixel is consumed on a rising edge where BUSY=1 and CE=1.
// EOL/EOF/EDGE describe that pixel and depend on registered state only.
// ---------------------------------------------------------------------------
module raster_scan_cnt #(
  parameter int COL_W  = 8,
  parameter int ROW_W  = 8,
  parameter int COLS   = 256,
  parameter int ROWS   = 256,
  parameter int BORDER = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             START,
  input  logic             CE,
  output logic [COL_W-1:0] COL,
  output logic [ROW_W-1:0] ROW,
  output logic             BUSY,
  output logic             EOL,
  output logic             EOF,
  output logic             EDGE,
  output logic             DONE,
  output logic [1:0]       fsm_state
);

  // Reject parameter sets that cannot describe a legal frame.
  generate
    if (COLS < 2 || COLS > (1 << COL_W)) begin : g_bad_cols
      $error("raster_scan_cnt: COLS must be in 2..2**COL_W");
    end
    if (ROWS < 2 || ROWS > (1 << ROW_W)) begin : g_bad_rows
      $error("raster_scan_cnt: ROWS must be in 2..2**ROW_W");
    end
    if (BORDER < 0 || 2 * BORDER > COLS || 2 * BORDER > ROWS) begin : g_bad_border
      $error("raster_scan_cnt: BORDER must satisfy 0 <= 2*BORDER <= min(COLS,ROWS)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state;

  // All bound comparisons are done at 32 bits so COLS = 2**COL_W is handled
  // by an explicit compare rather than by counter overflow.
  localparam logic [31:0]      COL_LAST = 32'(COLS - 1);
  localparam logic [31:0]      ROW_LAST = 32'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [31:0] col_x;
  logic [31:0] row_x;
  logic        col_last;
  logic        row_last;
  logic        in_border;

  assign col_x    = 32'(COL);
  assign row_x    = 32'(ROW);
  assign col_last = (col_x == COL_LAST);
  assign row_last = (row_x == ROW_LAST);

  generate
    if (BORDER == 0) begin : g_no_border
      assign in_border = 1'b0;
    end else begin : g_border
      localparam logic [31:0] B_LO  = 32'(BORDER);
      localparam logic [31:0] C_HI  = 32'(COLS - BORDER);
      localparam logic [31:0] R_HI  = 32'(ROWS - BORDER);
      assign in_border = (col_x < B_LO) || (col_x >= C_HI) ||
                         (row_x < B_LO) || (row_x >= R_HI);
    end
  endgenerate

  // Status outputs decode the registered state; no input reaches them.
  assign BUSY      = (state == S_RUN);
  assign DONE      = (state == S_FIN);
  assign EOL       = BUSY & col_last;
  assign EOF       = EOL & row_last;
  assign EDGE      = BUSY & in_border;
  assign fsm_state = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      COL   <= '0;
      ROW   <= '0;
    end else if (CLR) begin
      state <= S_IDLE;
      COL   <= '0;
      ROW   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_RUN;
            COL   <= '0;
            ROW   <= '0;
          end
        end
        S_RUN: begin
          if (CE) begin
            if (col_last && row_last) begin
              // Last pixel consumed: park the address at the origin.
              state <= S_FIN;
              COL   <= '0;
              ROW   <= '0;
            end else if (col_last) begin
              COL <= '0;
              ROW <= ROW + ROW_ONE;
            end else begin
              COL <= COL + COL_ONE;
            end
          end
        end
        S_FIN: begin
          // Counters are already zero; START here chains the next frame.
          state <= START ? S_RUN : S_IDLE;
          COL   <= '0;
          ROW   <= '0;
        end
        default: begin
          state <= S_IDLE;
          COL   <= '0;
          ROW   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_scan_cnt.sv
// tb_raster_scan_cnt
// ---------------------------------------------------------------------------
// Drives three instances of raster_scan_cnt from shared stimulus:
//   d0: 4x3 frame, BORDER=1
//   d1: 4x3 frame, BORDER=0
//   d2: 4x4 frame, COL_W=ROW_W=2 (counters at full width), BORDER=1
// A reference model per instance tracks a linear pixel index and a mode;
// column and row are derived from the index by division and modulo.
// ---------------------------------------------------------------------------
module tb_raster_scan_cnt;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clr;
  logic start;
  logic ce;

  // ---------------- DUT outputs ----------------
  logic [7:0] col0, row0, col1, row1;
  logic [1:0] col2, row2;
  logic       busy0, eol0, eof0, edge0, done0;
  logic       busy1, eol1, eof1, edge1, done1;
  logic       busy2, eol2, eof2, edge2, done2;
  logic [1:0] st0, st1, st2;

  raster_scan_cnt #(.COL_W(8), .ROW_W(8), .COLS(4), .ROWS(3), .BORDER(1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .START(start), .CE(ce),
    .COL(col0), .ROW(row0), .BUSY(busy0), .EOL(eol0), .EOF(eof0),
    .EDGE(edge0), .DONE(done0), .fsm_state(st0)
  );

  raster_scan_cnt #(.COL_W(8), .ROW_W(8), .COLS(4), .ROWS(3), .BORDER(0)) dut1 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .START(start), .CE(ce),
    .COL(col1), .ROW(row1), .BUSY(busy1), .EOL(eol1), .EOF(eof1),
    .EDGE(edge1), .DONE(done1), .fsm_state(st1)
  );

  raster_scan_cnt #(.COL_W(2), .ROW_W(2), .COLS(4), .ROWS(4), .BORDER(1)) dut2 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .START(start), .CE(ce),
    .COL(col2), .ROW(row2), .BUSY(busy2), .EOL(eol2), .EOF(eof2),
    .EDGE(edge2), .DONE(done2), .fsm_state(st2)
  );

  // ---------------- reference model ----------------
  localparam int M_COLS [3] = '{4, 4, 4};
  localparam int M_ROWS [3] = '{3, 3, 4};
  localparam int M_BORD [3] = '{1, 0, 1};

  // mode: 0 idle, 1 scanning, 2 frame finished
  int m_mode [3];
  int m_pix  [3];
  int done_cnt0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0;
      m_pix[k]  = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int total;
      total = M_COLS[k] * M_ROWS[k];
      if (!rst_n || clr) begin
        m_mode[k] = 0;
        m_pix[k]  = 0;
      end else if (m_mode[k] == 0) begin
        if (start) begin
          m_mode[k] = 1;
          m_pix[k]  = 0;
        end
      end else if (m_mode[k] == 1) begin
        if (ce) begin
          if (m_pix[k] == total - 1) begin
            m_mode[k] = 2;
            m_pix[k]  = 0;
          end else begin
            m_pix[k] = m_pix[k] + 1;
          end
        end
      end else begin
        m_mode[k] = start ? 1 : 0;
        m_pix[k]  = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, got, exp);
  endtask

  task automatic check_one(input int k, input logic [31:0] c, input logic [31:0] r,
                           input logic b, input logic el, input logic ef,
                           input logic ed, input logic dn);
    int ec, er, bd;
    logic eb, eedge;
    ec    = m_pix[k] % M_COLS[k];
    er    = m_pix[k] / M_COLS[k];
    bd    = M_BORD[k];
    eb    = (m_mode[k] == 1);
    eedge = eb && ((ec < bd) || (ec >= M_COLS[k] - bd) ||
                   (er < bd) || (er >= M_ROWS[k] - bd));
    chk($sformatf("d%0d_col", k),  c, 32'(ec));
    chk($sformatf("d%0d_row", k),  r, 32'(er));
    chk($sformatf("d%0d_busy", k), 32'(b), 32'(eb));
    chk($sformatf("d%0d_eol", k),  32'(el), 32'(eb && ec == M_COLS[k] - 1));
    chk($sformatf("d%0d_eof", k),  32'(ef), 32'(eb && m_pix[k] == M_COLS[k] * M_ROWS[k] - 1));
    chk($sformatf("d%0d_edge", k), 32'(ed), 32'(eedge));
    chk($sformatf("d%0d_done", k), 32'(dn), 32'(m_mode[k] == 2));
  endtask

  task automatic check_all();
    check_one(0, 32'(col0), 32'(row0), busy0, eol0, eof0, edge0, done0);
    check_one(1, 32'(col1), 32'(row1), busy1, eol1, eof1, edge1, done1);
    check_one(2, 32'(col2), 32'(row2), busy2, eol2, eof2, edge2, done2);
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are checked 1ns after the
  // rising edge once the model has consumed the same inputs.
  task automatic step(input logic r, input logic c, input logic s, input logic e);
    @(negedge clk);
    rst_n = r;
    clr   = c;
    start = s;
    ce    = e;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (done0) done_cnt0++;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_pass    = 0;
    n_total   = 0;
    done_cnt0 = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    start = 1'b0;
    ce    = 1'b0;
    model_reset();
    #1;
    check_all();

    // START and CE have no effect while reset is held.
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    // Out of reset: CE in IDLE is ignored.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);

    // Full scan: START then continuous CE (d2 needs 16 pixels).
    step(1, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1);
    chk("d0_done_after_12_ce", 32'(done0), 32'd1);
    chk("d0_busy_in_fin", 32'(busy0), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    chk("d2_done_after_16_ce", 32'(done2), 32'd1);
    step(1, 0, 0, 1);
    chk("d0_done_count_full_scan", 32'(done_cnt0), 32'd1);

    // CE gaps: toggle 1,0 so the scan takes twice as many cycles.
    step(1, 0, 1, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, (i % 2) == 0);

    // START held during RUN and through FIN: no restart mid-frame,
    // immediate back-to-back frame from FIN.
    for (int i = 0; i < 30; i++) step(1, 0, 1, 1);
    step(1, 0, 0, 0);

    // CLR at (2,1) with START asserted: abort to IDLE, no DONE.
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    chk("d0_col_before_clr", 32'(col0), 32'd2);
    chk("d0_row_before_clr", 32'(row0), 32'd1);
    step(1, 1, 1, 1);
    step(1, 0, 0, 1);
    chk("d0_no_done_after_clr", 32'(done0), 32'd0);

    // Asynchronous reset mid-frame at (2,1), between clock edges.
    step(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("d0_async_rst_busy", 32'(busy0), 32'd0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      step(1'b1,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
